// File: rtl/wb_pkg.sv
// Shared types for the writeback/register-file slice: queue entry, drain states, register codes.
package wb_pkg;

  localparam int NUM_REGS = 16;
  localparam logic [3:0] REG_RAX = 4'd0;
  localparam logic [3:0] REG_RDX = 4'd2;

  typedef enum logic {PRIMARY, SPECIAL} wb_state_e;

  typedef struct packed {
    logic [3:0]  dest;
    logic        destValid;
    logic [63:0] destValue;
    logic [3:0]  special;
    logic        specialValid;
    logic [63:0] specialValue;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] regBit(logic [3:0] code, logic en);
    return en ? (NUM_REGS'(1) << code) : '0;
  endfunction

endpackage

// File: rtl/wb_queue.sv
// In-order writeback queue of wb_entry_t; exposes head, occupancy and the raw slot array
// so the top can build the pending-write mask.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  wb_entry_t                  pushEntry,
  input  logic                       pop,
  output wb_entry_t                  headEntry,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output wb_entry_t                  entries [DEPTH],
  output logic [DEPTH-1:0]           entryValid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t      mem [DEPTH];
  logic [PW-1:0]  rdPtr;
  logic [PW-1:0]  wrPtr;
  logic           doPush;
  logic           doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  assign headEntry = mem[rdPtr];
  assign entries   = mem;

  // mem contents need no reset; entryValid gates every consumer of the slot data
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
      entryValid <= '0;
    end else begin
      if (doPush) begin
        entryValid[wrPtr] <= 1'b1;
        wrPtr             <= wrPtr + PW'(1);
      end
      if (doPop) begin
        entryValid[rdPtr] <= 1'b0;
        rdPtr             <= rdPtr + PW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// Write end of the architectural register file: queues retiring results and drains one
// register write per cycle. Optional write-through view via WB_BYPASS_EN.
module writeback_regfile
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        writebackValidIn,
  input  logic [0:3]  destRegIn,
  input  logic        destRegValidIn,
  input  logic [63:0] destRegValueIn,
  input  logic [0:3]  destRegisterSpecialIn,
  input  logic        destRegisterSpecialValidIn,
  input  logic [63:0] destRegSpecialValueIn,
  output logic [63:0] registerFileOut [NUM_REGS],
  output logic        wbStallOut,
  output logic [15:0] pendingMaskOut,
  output logic [63:0] retiredCountOut
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_state_e     state, nextState;
  wb_entry_t     pushEntry, headEntry;
  wb_entry_t     entries [DEPTH];
  logic [DEPTH-1:0] entryValid;
  logic          qFull, qEmpty, pop;
  logic [CW-1:0] qCount;
  logic [63:0]   regs [NUM_REGS];
  logic          writeEn;
  logic [3:0]    writeAddr;
  logic [63:0]   writeData;

  always_comb begin
    pushEntry              = '0;
    pushEntry.dest         = destRegIn;
    pushEntry.destValid    = destRegValidIn;
    pushEntry.destValue    = destRegValueIn;
    pushEntry.special      = destRegisterSpecialIn;
    pushEntry.specialValid = destRegisterSpecialValidIn;
    pushEntry.specialValue = destRegSpecialValueIn;
  end

  wb_queue #(.DEPTH(DEPTH)) uQueue (
    .clk        (clk),
    .reset      (reset),
    .push       (writebackValidIn && !qFull),
    .pushEntry  (pushEntry),
    .pop        (pop),
    .headEntry  (headEntry),
    .full       (qFull),
    .empty      (qEmpty),
    .count      (qCount),
    .entries    (entries),
    .entryValid (entryValid)
  );

  assign wbStallOut = (qCount == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) state <= PRIMARY;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    writeEn   = 1'b0;
    writeAddr = '0;
    writeData = '0;
    pop       = 1'b0;
    case (state)
      PRIMARY: begin
        if (!qEmpty) begin
          writeEn   = headEntry.destValid;
          writeAddr = headEntry.dest;
          writeData = headEntry.destValue;
          if (headEntry.specialValid) nextState = SPECIAL;
          else                        pop       = 1'b1;
        end
      end
      SPECIAL: begin
        writeEn   = 1'b1;
        writeAddr = headEntry.special;
        writeData = headEntry.specialValue;
        pop       = 1'b1;
        nextState = PRIMARY;
      end
      default: nextState = PRIMARY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      retiredCountOut <= '0;
    end else begin
      if (writeEn) regs[writeAddr] <= writeData;
      if (pop)     retiredCountOut <= retiredCountOut + 64'd1;
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
`ifdef WB_BYPASS_EN
      registerFileOut[r] = (writeEn && (writeAddr == 4'(r))) ? writeData : regs[r];
`else
      registerFileOut[r] = regs[r];
`endif
    end
  end

  // A dual-dest entry keeps both bits until it pops, even after its primary write lands.
  always_comb begin
    pendingMaskOut = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i]) begin
        pendingMaskOut = pendingMaskOut
                       | regBit(entries[i].dest, entries[i].destValid)
                       | regBit(entries[i].special, entries[i].specialValid);
      end
    end
`ifdef WB_BYPASS_EN
    pendingMaskOut = pendingMaskOut & ~regBit(writeAddr, writeEn);
`endif
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile (default build): vector table plus multi-cycle sequences.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        writebackValidIn;
  logic [0:3]  destRegIn;
  logic        destRegValidIn;
  logic [63:0] destRegValueIn;
  logic [0:3]  destRegisterSpecialIn;
  logic        destRegisterSpecialValidIn;
  logic [63:0] destRegSpecialValueIn;
  logic [63:0] registerFileOut [16];
  logic        wbStallOut;
  logic [15:0] pendingMaskOut;
  logic [63:0] retiredCountOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_regfile #(.DEPTH(2)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .writebackValidIn           (writebackValidIn),
    .destRegIn                  (destRegIn),
    .destRegValidIn             (destRegValidIn),
    .destRegValueIn             (destRegValueIn),
    .destRegisterSpecialIn      (destRegisterSpecialIn),
    .destRegisterSpecialValidIn (destRegisterSpecialValidIn),
    .destRegSpecialValueIn      (destRegSpecialValueIn),
    .registerFileOut            (registerFileOut),
    .wbStallOut                 (wbStallOut),
    .pendingMaskOut             (pendingMaskOut),
    .retiredCountOut            (retiredCountOut)
  );

  typedef struct {
    logic [3:0]  dest;
    logic        dValid;
    logic [63:0] dVal;
    logic [3:0]  spec;
    logic        sValid;
    logic [63:0] sVal;
    logic [3:0]  chkReg;
    logic [63:0] chkVal;
    logic [63:0] expRetired;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic dv, input logic [63:0] dval,
                       input logic [3:0] s, input logic sv, input logic [63:0] sval);
    writebackValidIn           = v;
    destRegIn                  = d;
    destRegValidIn             = dv;
    destRegValueIn             = dval;
    destRegisterSpecialIn      = s;
    destRegisterSpecialValidIn = sv;
    destRegSpecialValueIn      = sval;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 64'd0, 4'd0, 1'b0, 64'd0);
  endtask

  // Present an entry and hold it until an edge where the stall seen before that edge was low.
  task automatic pushHold(input logic [3:0] d, input logic [63:0] dval,
                          input logic [3:0] s, input logic [63:0] sval, output logic sawStall);
    logic wasStall;
    logic done;
    sawStall = 1'b0;
    done     = 1'b0;
    drive(1'b1, d, 1'b1, dval, s, 1'b1, sval);
    for (int k = 0; k < 20 && !done; k++) begin
      wasStall = wbStallOut;
      if (wasStall) sawStall = 1'b1;
      tick(1);
      if (!wasStall) done = 1'b1;
    end
    if (!done) check("push_accept_timeout", 64'd0, 64'd1);
    idle();
  endtask

  logic allZero;
  logic stalled;
  logic anyStall;

  initial begin
    vecs[0] = '{4'd3,  1'b1, 64'hDEAD,             4'd0,  1'b0, 64'd0,      4'd3,  64'hDEAD,             64'd1};
    vecs[1] = '{4'd0,  1'b1, 64'd5,                4'd2,  1'b1, 64'd7,      4'd2,  64'd7,                64'd2};
    vecs[2] = '{4'd5,  1'b1, 64'd1,                4'd5,  1'b1, 64'd9,      4'd5,  64'd9,                64'd3};
    vecs[3] = '{4'd6,  1'b0, 64'h77,               4'd6,  1'b0, 64'h88,     4'd6,  64'd0,                64'd4};
    vecs[4] = '{4'd15, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 1'b0, 64'd0,    4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5};
    vecs[5] = '{4'd9,  1'b0, 64'hBAD,              4'd9,  1'b1, 64'h1234,   4'd9,  64'h1234,             64'd6};
    vecs[6] = '{4'd3,  1'b1, 64'h42,               4'd0,  1'b0, 64'd0,      4'd3,  64'h42,               64'd7};

    idle();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);

    allZero = 1'b1;
    for (int r = 0; r < 16; r++) if (registerFileOut[r] !== 64'd0) allZero = 1'b0;
    check("reset_regs_zero", {63'd0, allZero}, 64'd1);
    check("reset_stall", {63'd0, wbStallOut}, 64'd0);
    check("reset_mask", {48'd0, pendingMaskOut}, 64'd0);
    check("reset_retired", retiredCountOut, 64'd0);

    // single-dest push: pending bit set one cycle, value visible the cycle after the write
    drive(1'b1, 4'd3, 1'b1, 64'hDEAD, 4'd0, 1'b0, 64'd0);
    tick(1);
    idle();
    check("t1_mask_pending", {48'd0, pendingMaskOut}, 64'h0008);
    check("t1_reg3_not_yet", registerFileOut[3], 64'd0);
    tick(1);
    check("t1_reg3_visible", registerFileOut[3], 64'hDEAD);
    check("t1_mask_cleared", {48'd0, pendingMaskOut}, 64'd0);
    check("t1_retired", retiredCountOut, 64'd1);

    reset = 1'b1;
    tick(1);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vecs[i].dest, vecs[i].dValid, vecs[i].dVal, vecs[i].spec, vecs[i].sValid, vecs[i].sVal);
      tick(1);
      idle();
      tick(3);
      check($sformatf("vec%0d_reg%0d", i, vecs[i].chkReg), registerFileOut[vecs[i].chkReg], vecs[i].chkVal);
      check($sformatf("vec%0d_retired", i), retiredCountOut, vecs[i].expRetired);
      check($sformatf("vec%0d_mask", i), {48'd0, pendingMaskOut}, 64'd0);
    end
    check("vec_rax_kept", registerFileOut[0], 64'd5);

    // dual-dest timing: RAX first, RDX one cycle later, retire only after RDX
    drive(1'b1, 4'd0, 1'b1, 64'hA5, 4'd2, 1'b1, 64'hB6);
    tick(1);
    idle();
    check("dual_mask_both", {48'd0, pendingMaskOut}, 64'h0005);
    tick(1);
    check("dual_rax_written", registerFileOut[0], 64'hA5);
    check("dual_rdx_old", registerFileOut[2], 64'd7);
    check("dual_retired_hold", retiredCountOut, 64'd7);
    check("dual_mask_held", {48'd0, pendingMaskOut}, 64'h0005);
    tick(1);
    check("dual_rdx_written", registerFileOut[2], 64'hB6);
    check("dual_retired_inc", retiredCountOut, 64'd8);
    check("dual_mask_clear", {48'd0, pendingMaskOut}, 64'd0);

    // back-to-back dual-dest pushes into a 2-deep queue
    anyStall = 1'b0;
    pushHold(4'd1,  64'h11, 4'd4,  64'h44, stalled);  anyStall |= stalled;
    pushHold(4'd7,  64'h77, 4'd8,  64'h88, stalled);  anyStall |= stalled;
    check("b2b_full_stall", {63'd0, wbStallOut}, 64'd1);
    pushHold(4'd10, 64'hAA, 4'd11, 64'hBB, stalled);  anyStall |= stalled;
    check("b2b_held_input_stalled", {63'd0, anyStall}, 64'd1);
    tick(8);
    check("b2b_reg1",  registerFileOut[1],  64'h11);
    check("b2b_reg4",  registerFileOut[4],  64'h44);
    check("b2b_reg7",  registerFileOut[7],  64'h77);
    check("b2b_reg8",  registerFileOut[8],  64'h88);
    check("b2b_reg10", registerFileOut[10], 64'hAA);
    check("b2b_reg11", registerFileOut[11], 64'hBB);
    check("b2b_retired", retiredCountOut, 64'd11);
    check("b2b_stall_clear", {63'd0, wbStallOut}, 64'd0);
    check("b2b_mask_clear", {48'd0, pendingMaskOut}, 64'd0);

    // reset with two entries queued discards them
    drive(1'b1, 4'd12, 1'b1, 64'h12, 4'd13, 1'b1, 64'h13);
    tick(1);
    drive(1'b1, 4'd14, 1'b1, 64'h14, 4'd0, 1'b0, 64'd0);
    tick(1);
    idle();
    check("rst_two_queued_stall", {63'd0, wbStallOut}, 64'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    allZero = 1'b1;
    for (int r = 0; r < 16; r++) if (registerFileOut[r] !== 64'd0) allZero = 1'b0;
    check("rst_regs_zero", {63'd0, allZero}, 64'd1);
    check("rst_mask", {48'd0, pendingMaskOut}, 64'd0);
    check("rst_retired", retiredCountOut, 64'd0);
    check("rst_stall", {63'd0, wbStallOut}, 64'd0);
    tick(5);
    check("rst_reg13_never", registerFileOut[13], 64'd0);
    check("rst_reg14_never", registerFileOut[14], 64'd0);
    check("rst_retired_after", retiredCountOut, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
